// File: rtl/residual_map_seq_pkg.sv
// Shared width defaults for the residual mapping pipeline.
// These are the JPEG-LS values used by the block's parameters.
package residual_map_seq_pkg;
  localparam int RESIDUAL_LENGTH    = 9;
  localparam int MODRESIDUAL_LENGTH = 8;
  localparam int FRAME_CNT_LENGTH   = 16;
endpackage

// File: rtl/residual_map_seq_err_map_stage.sv
// Combinational modulo reduction (Errval -> e) and the JPEG-LS fold of a
// reduced residual into a non-negative MErrval.
module err_map_stage
  import residual_map_seq_pkg::*;
#(
  parameter int residual_length    = RESIDUAL_LENGTH,
  parameter int modresidual_length = MODRESIDUAL_LENGTH
) (
  input  logic [residual_length-1:0]    err_in,
  input  logic                          sign_flip,
  output logic [modresidual_length-1:0] e_out,
  input  logic [modresidual_length-1:0] e_in,
  output logic [modresidual_length-1:0] merr_out
);

  logic [modresidual_length-1:0] w_dbl;

  // Truncating to the low bits is the modulo-RANGE reduction.
  assign e_out = modresidual_length'(sign_flip ? -err_in : err_in);

  // -2e-1 equals the bitwise inverse of 2e, so the fold never overflows.
  assign w_dbl    = {e_in[modresidual_length-2:0], 1'b0};
  assign merr_out = e_in[modresidual_length-1] ? ~w_dbl : w_dbl;

endmodule

// File: rtl/residual_map_seq.sv
// Frame sequencer around a two-stage reduce/map pipeline with ready/valid
// handshakes on both sides and a done pulse once the last sample leaves.
module residual_map_seq
  import residual_map_seq_pkg::*;
#(
  parameter int residual_length    = RESIDUAL_LENGTH,
  parameter int modresidual_length = MODRESIDUAL_LENGTH,
  parameter int frame_cnt_length   = FRAME_CNT_LENGTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [frame_cnt_length-1:0]   frame_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [residual_length-1:0]    err_in,
  input  logic                          sign_flip,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [modresidual_length-1:0] merr_out,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_nxt;
  logic [frame_cnt_length-1:0]   r_len;
  logic [frame_cnt_length-1:0]   r_count;
  logic [frame_cnt_length-1:0]   w_count_nxt;
  logic                          r_s1_valid;
  logic [modresidual_length-1:0] r_s1_e;
  logic                          r_s1_last;
  logic                          r_s2_valid;
  logic [modresidual_length-1:0] r_s2_merr;
  logic                          r_s2_last;
  logic                          r_done;
  logic                          w_in_ready;
  logic                          w_busy;
  logic                          w_accept;
  logic                          w_s1_adv;
  logic                          w_out_fire;
  logic                          w_is_last;
  logic                          w_start_ok;
  logic [modresidual_length-1:0] w_e;
  logic [modresidual_length-1:0] w_merr;

  err_map_stage #(
    .residual_length    (residual_length),
    .modresidual_length (modresidual_length)
  ) u_map (
    .err_in    (err_in),
    .sign_flip (sign_flip),
    .e_out     (w_e),
    .e_in      (r_s1_e),
    .merr_out  (w_merr)
  );

  assign w_s1_adv    = !r_s2_valid || out_ready;
  assign w_accept    = in_valid && w_in_ready;
  assign w_out_fire  = r_s2_valid && out_ready;
  assign w_count_nxt = r_count + {{(frame_cnt_length-1){1'b0}}, 1'b1};
  assign w_is_last   = (w_count_nxt == r_len);
  assign w_start_ok  = start && (frame_len != {frame_cnt_length{1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_start_ok ? ST_RUN : ST_IDLE;
      ST_RUN:   w_state_nxt = (w_accept && w_is_last) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: w_state_nxt = (w_out_fire && r_s2_last) ? ST_IDLE : ST_DRAIN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_in_ready = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_busy     = 1'b1;
        w_in_ready = !r_s1_valid || w_s1_adv;
      end
      ST_DRAIN: begin
        w_busy     = 1'b1;
        w_in_ready = 1'b0;
      end
      default: begin
        w_busy     = 1'b0;
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Frame length is latched only on an accepted start; count tracks accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= {frame_cnt_length{1'b0}};
      r_count <= {frame_cnt_length{1'b0}};
    end else if ((r_state == ST_IDLE) && w_start_ok) begin
      r_len   <= frame_len;
      r_count <= {frame_cnt_length{1'b0}};
    end else if (w_accept) begin
      r_count <= w_count_nxt;
    end
  end

  // Stage 1 may fill while stage 2 is stalled, and load while stage 2 drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_e     <= {modresidual_length{1'b0}};
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_merr  <= {modresidual_length{1'b0}};
      r_s2_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_e     <= w_e;
        r_s1_last  <= w_is_last;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_merr <= w_merr;
          r_s2_last <= r_s1_last;
        end
      end
      r_done <= (r_state == ST_DRAIN) && w_out_fire && r_s2_last;
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign out_valid = r_s2_valid;
  assign merr_out  = r_s2_merr;
  assign out_last  = r_s2_valid && r_s2_last;
  assign done      = r_done;

endmodule

// File: doc/residual_map_seq.md
RESIDUAL_MAP_SEQ -- requirements
Module: residual_map_seq

Interface
REQ-001 SHALL have parameter residual_length, default `residual_length (shared include), meaning prediction residual width in bits, two's complement.
REQ-002 SHALL have parameter modresidual_length, default `modresidual_length (shared include), meaning reduced/mapped residual width; RANGE = 2^modresidual_length.
REQ-003 SHALL have parameter frame_cnt_length, default 16, meaning sample-counter width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a frame.
REQ-007 frame_len  input  frame_cnt_length  samples in frame; sampled on accepted start.
REQ-008 in_valid  input  1  residual present.
REQ-009 in_ready  output  1  block accepts residual this cycle.
REQ-010 err_in  input  residual_length  raw residual Errval.
REQ-011 sign_flip  input  1  context SIGN: negate err_in before reduction.
REQ-012 out_valid  output  1  mapped value present.
REQ-013 out_ready  input  1  downstream accepts mapped value.
REQ-014 merr_out  output  modresidual_length  mapped residual MErrval.
REQ-015 out_last  output  1  qualifies final sample of frame, valid with out_valid.
REQ-016 busy  output  1  high in RUN or DRAIN.
REQ-017 done  output  1  one-cycle pulse when frame fully drained.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN.
REQ-019 IDLE: start=1 with frame_len!=0 -> RUN, latch frame_len, clear count; start with frame_len=0 ignored, stay IDLE.
REQ-020 RUN: accept residual when in_valid && in_ready; after accepting sample number frame_len -> DRAIN.
REQ-021 DRAIN: when out_valid && out_ready && out_last -> IDLE, done=1 that cycle's following edge for exactly one cycle.
REQ-022 start SHALL be ignored in RUN and DRAIN.
REQ-023 in_ready SHALL be 0 outside RUN; in RUN, in_ready = !s1_valid || s1 advancing.
REQ-024 Stage 1 SHALL register e = sign_flip ? -err_in : err_in, truncated to low modresidual_length bits (modulo RANGE reduction, two's complement result in [-RANGE/2, RANGE/2-1]), plus last flag.
REQ-025 Stage 2 SHALL register merr = (e>=0) ? 2e : -2e-1, unsigned, modresidual_length bits, no overflow.
REQ-026 Stage 1 advances when !s2_valid || out_ready; stage 2 holds value and out_valid stable until out_ready.
REQ-027 Latency SHALL be 2 cycles accept-to-out_valid when unstalled; throughput 1 sample/cycle under continuous out_ready.
REQ-028 No sample SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-029 out_last SHALL be 1 only on the sample whose accept count equals latched frame_len.
REQ-030 Simultaneous stage-1 load and stage-2 drain in one cycle SHALL be supported.

Reset
REQ-031 reset=1 SHALL force IDLE, count=0, s1_valid=s2_valid=0, in_ready=0, out_valid=0, out_last=0, merr_out=0, busy=0, done=0.
REQ-032 reset mid-frame SHALL discard all in-flight samples with no done pulse; reset overrides start.

Structure
REQ-033 Width constants SHALL come from Parameterize_JPEGLS.v; state encodings SHALL be localparams in the module.
REQ-034 Modulo-reduce-and-map arithmetic SHALL be a combinational sub-module err_map_stage; FSM, counter and pipeline registers remain in residual_map_seq.

Verification (residual_length=9, modresidual_length=8)
REQ-035 start, frame_len=4, out_ready=1, err_in 0,1,-1,127 back-to-back -> merr 0,2,1,254, first out_valid 2 cycles after first accept, out_last on 4th, done one cycle after.
REQ-036 err_in 200 -> 111; err_in -200 -> 112; err_in -128 -> 255; err_in 5 with sign_flip=1 -> 9.
REQ-037 frame_len=3, out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, merr_out stable; release -> all 3 delivered in order, once each.
REQ-038 start with frame_len=0 -> stays IDLE, busy=0; start during RUN -> ignored, count unaffected.
REQ-039 reset asserted after 2 of 6 accepts -> next cycle all outputs at reset values, no done; new frame then runs cleanly.
